// File: rtl/bit_index_sequencer.sv
// bit_index_sequencer: accepts an N-bit request bitmap and streams the index
// of every set bit, highest index first, one per accepted output transfer.
// Each emitted bit is cleared from the pending set. Done pulses once per vector.

// MSB-priority find-first-one encoder: index of the highest set bit.
module bit_index_ffo #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    // Ascending scan, so the last hit (highest set bit) wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
                any_o = 1'b1;
            end
        end
    end
endmodule

module bit_index_sequencer #(
    parameter int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          Clock_i,
    input  logic          Reset_N_i,
    input  logic          LoadValid_i,
    output logic          LoadReady_o,
    input  logic [N-1:0]  LoadVector_i,
    output logic          OutValid_o,
    input  logic          OutReady_i,
    output logic [IW-1:0] OutIndex_o,
    output logic          OutLast_o,
    output logic          Done_o,
    output logic [N-1:0]  Pending_o
);
    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $fatal(1, "bit_index_sequencer: N must be a power of 2 and >= 2");
    end

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t        state_q;
    logic [N-1:0]  pending_q;
    logic [N-1:0]  pending_d;
    logic          done_q;
    logic [IW-1:0] hi_idx;
    logic          hi_any;
    logic          one_hot;

    bit_index_ffo #(.N(N), .IW(IW)) u_ffo (
        .vec_i (pending_q),
        .idx_o (hi_idx),
        .any_o (hi_any)
    );

    // Pending set with the currently presented bit removed.
    always_comb begin
        pending_d = pending_q & ~({{(N-1){1'b0}}, 1'b1} << hi_idx);
    end

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    always_comb begin
        one_hot = hi_any && ((pending_q & (pending_q - N'(1))) == '0);
    end

    // Handshake outputs are decoded from registered state; reset masks them.
    always_comb begin
        LoadReady_o = Reset_N_i && (state_q == IDLE);
        OutValid_o  = Reset_N_i && (state_q == EMIT);
        OutIndex_o  = hi_idx;
        OutLast_o   = one_hot;
        Done_o      = done_q;
        Pending_o   = pending_q;
    end

    // Control FSM: capture in IDLE, drain one bit per transfer in EMIT.
    always_ff @(posedge Clock_i) begin
        if (!Reset_N_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (LoadValid_i) begin
                        pending_q <= LoadVector_i;
                        if (LoadVector_i != '0) state_q <= EMIT;
                        else                    done_q  <= 1'b1;
                    end
                end
                EMIT: begin
                    // LoadValid is ignored here; only OutReady moves the stream.
                    if (OutReady_i) begin
                        pending_q <= pending_d;
                        if (one_hot) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_index_sequencer.sv
// Bench for bit_index_sequencer: a queue-based model of the expected index
// stream checked every cycle, plus hand-computed literal checkpoints.
module tb_bit_index_sequencer;
    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [N-1:0]  load_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          done;
    logic [N-1:0]  pending;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    bit_index_sequencer #(.N(N)) dut (
        .Clock_i      (clk),
        .Reset_N_i    (rst_n),
        .LoadValid_i  (load_valid),
        .LoadReady_o  (load_ready),
        .LoadVector_i (load_vec),
        .OutValid_o   (out_valid),
        .OutReady_i   (out_ready),
        .OutIndex_o   (out_idx),
        .OutLast_o    (out_last),
        .Done_o       (done),
        .Pending_o    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Model: the indices still to be emitted, highest first.
    int q[$];
    bit m_done = 1'b0;

    function automatic int q_bitmap();
        int b = 0;
        foreach (q[i]) b |= (1 << q[i]);
        return b;
    endfunction

    // Compare at negedge, then advance the model using the inputs held for the next edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", int'(out_valid), int'(rst_n && q.size() > 0));
            check("m_load_ready", int'(load_ready), int'(rst_n && q.size() == 0));
            check("m_done", int'(done), int'(m_done));
            check("m_pending", int'(pending), q_bitmap());
            if (out_valid && q.size() > 0) begin
                check("m_out_index", int'(out_idx), q[0]);
                check("m_out_last", int'(out_last), int'(q.size() == 1));
            end
        end
        m_done = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (load_valid) begin
                for (int i = N - 1; i >= 0; i--) if (load_vec[i]) q.push_back(i);
                if (load_vec == '0) m_done = 1'b1;
            end
        end else if (out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) m_done = 1'b1;
        end
    end

    // Advance one edge; inputs change and literals are read 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N-1:0] v);
        load_valid = 1'b1;
        load_vec   = v;
        cyc();
        load_valid = 1'b0;
    endtask

    initial begin
        // Reset
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_pending", int'(pending), 0);
        check("rst_done", int'(done), 0);
        check("rst_load_ready", int'(load_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_load_ready", int'(load_ready), 1);
        cyc();

        // A5 with OutReady high: 7,5,2,0 then Done
        out_ready = 1'b1;
        load(8'hA5);
        check("a5_idx0", int'(out_idx), 7);
        check("a5_last0", int'(out_last), 0);
        cyc(); check("a5_idx1", int'(out_idx), 5);
        cyc(); check("a5_idx2", int'(out_idx), 2);
        cyc(); check("a5_idx3", int'(out_idx), 0);
        check("a5_last3", int'(out_last), 1);
        cyc();
        check("a5_done", int'(done), 1);
        check("a5_load_ready", int'(load_ready), 1);
        check("a5_pending_end", int'(pending), 0);
        cyc();
        check("a5_done_drop", int'(done), 0);

        // A5 with backpressure for three cycles
        out_ready = 1'b0;
        load(8'hA5);
        for (int i = 0; i < 3; i++) begin
            check("bp_idx_hold", int'(out_idx), 7);
            check("bp_pending_hold", int'(pending), 8'hA5);
            if (i < 2) cyc();
        end
        out_ready = 1'b1;
        repeat (4) cyc();
        check("bp_done", int'(done), 1);
        cyc();

        // Empty vector: Done only
        load(8'h00);
        check("zero_done", int'(done), 1);
        check("zero_out_valid", int'(out_valid), 0);
        check("zero_load_ready", int'(load_ready), 1);
        cyc();
        check("zero_done_once", int'(done), 0);

        // Single bit then full vector back-to-back
        load(8'h01);
        check("one_idx", int'(out_idx), 0);
        check("one_last", int'(out_last), 1);
        cyc();
        load(8'hFF);
        for (int i = 0; i < 8; i++) begin
            check("ff_idx", int'(out_idx), 7 - i);
            check("ff_last", int'(out_last), int'(i == 7));
            cyc();
        end
        check("ff_done", int'(done), 1);
        cyc();

        // Load attempt during EMIT is ignored; accepted once back in IDLE
        load(8'h90);
        load_valid = 1'b1;
        load_vec   = 8'h0F;
        check("ign_idx0", int'(out_idx), 7);
        cyc();
        check("ign_idx1", int'(out_idx), 4);
        check("ign_pending", int'(pending), 8'h10);
        cyc();
        check("ign_idle_ready", int'(load_ready), 1);
        cyc();
        load_valid = 1'b0;
        check("reload_idx", int'(out_idx), 3);
        repeat (4) cyc();
        check("reload_done", int'(done), 1);
        cyc();

        // Mid-stream reset
        load(8'hF0);
        cyc();
        cyc();
        check("mid_idx", int'(out_idx), 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        cyc();
        check("mid_pending", int'(pending), 0);
        check("mid_done", int'(done), 0);
        rst_n = 1'b1;
        #1;
        check("mid_load_ready", int'(load_ready), 1);
        load(8'h02);
        check("after_idx", int'(out_idx), 1);
        check("after_last", int'(out_last), 1);
        check("after_no_done", int'(done), 0);
        cyc();
        check("after_done", int'(done), 1);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end
endmodule
